// File: rtl/alu_sequencer_pkg.sv
// Shared opcode and FSM state definitions for the ALU sequencer and its combinational core.
package alu_sequencer_pkg;
  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_NAND = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_NOR  = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_XNOR = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_ADD  = 4'h8;
  localparam logic [3:0] OP_SUB  = 4'h9;
  localparam logic [3:0] OP_MULT = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MULT = 2'd2,
    ST_RESP = 2'd3
  } state_t;
endpackage

// File: rtl/alu_sequencer_core.sv
// Combinational W-bit ALU: (op, x, y, cin) -> (out, cout). Holds no state.
module alu_core_4b
  import alu_sequencer_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] out,
  output logic         cout
);
  logic [W:0]     sum;
  logic [2*W-1:0] sh;

  // sub is x + ~y + cin, so cin=1 gives a plain two's-complement subtract
  assign sum = {1'b0, x} + {1'b0, (op == OP_SUB) ? ~y : y} + {{W{1'b0}}, cin};
  // bit W of the widened shift is the last bit pushed out; 0 when the amount is 0
  assign sh  = {{W{1'b0}}, x} << y[1:0];

  always_comb begin
    out  = '0;
    cout = 1'b0;
    case (op)
      OP_AND:  out = x & y;
      OP_NAND: out = ~(x & y);
      OP_OR:   out = x | y;
      OP_NOR:  out = ~(x | y);
      OP_XOR:  out = x ^ y;
      OP_XNOR: out = ~(x ^ y);
      OP_NOT:  out = ~x;
      OP_SHL:  begin out = sh[W-1:0]; cout = sh[W]; end
      OP_ADD,
      OP_SUB:  begin out = sum[W-1:0]; cout = sum[W]; end
      default: begin out = '0; cout = 1'b0; end
    endcase
  end
endmodule

// File: rtl/alu_sequencer.sv
// Valid/ready command sequencer around alu_core_4b: sticky carry, shift-add multiply,
// registered response held until consumed.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int W        = 4,
  parameter int MULT_CYC = W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [3:0]     req_op,
  input  logic [W-1:0]   req_x,
  input  logic [W-1:0]   req_y,
  input  logic           req_use_carry,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*W-1:0] rsp_result,
  output logic           rsp_cout,
  output logic           rsp_err,
  output logic           busy
);
  localparam int CW = (MULT_CYC > 1) ? $clog2(MULT_CYC) : 1;

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         use_carry;
  } cmd_t;

  state_t         state;
  cmd_t           cmd;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] prod, prod_nxt;
  logic           carry_flag, cin;
  logic [W-1:0]   core_out;
  logic           core_cout;

  assign cin      = cmd.use_carry ? carry_flag : (cmd.op == OP_SUB);
  assign prod_nxt = prod + (cmd.y[cnt] ? ({{W{1'b0}}, cmd.x} << cnt) : '0);

  alu_core_4b #(.W(W)) u_core (
    .op(cmd.op), .x(cmd.x), .y(cmd.y), .cin(cin), .out(core_out), .cout(core_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cmd        <= '0;
      cnt        <= '0;
      prod       <= '0;
      carry_flag <= 1'b0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            cmd       <= '{op: req_op, x: req_x, y: req_y, use_carry: req_use_carry};
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_op <= OP_SUB) begin
              state <= ST_EXEC;
            end else if (req_op == OP_MULT) begin
              state <= ST_MULT;
              cnt   <= '0;
              prod  <= '0;
            end else begin
              state      <= ST_RESP;
              rsp_valid  <= 1'b1;
              rsp_result <= '0;
              rsp_cout   <= 1'b0;
              rsp_err    <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          rsp_result <= {{W{1'b0}}, core_out};
          rsp_cout   <= core_cout;
          rsp_err    <= 1'b0;
          rsp_valid  <= 1'b1;
          state      <= ST_RESP;
          if (cmd.op == OP_ADD || cmd.op == OP_SUB || cmd.op == OP_SHL)
            carry_flag <= core_cout;
        end
        ST_MULT: begin
          prod <= prod_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(MULT_CYC - 1)) begin
            rsp_result <= prod_nxt;
            rsp_cout   <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: hand-computed results, latency, stall and reset behaviour.
module tb_alu_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready;
  logic [3:0] req_op, req_x, req_y;
  logic       req_use_carry;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_cout, rsp_err, busy;

  int n_cmp = 0;
  int n_bad = 0;

  alu_sequencer #(.W(4), .MULT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y), .req_use_carry(req_use_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Issue one command, measure edges from accept (accept edge counts as 1) to rsp_valid,
  // check the response, and consume it if rsp_ready is high.
  task automatic do_op(input string name, input logic [3:0] op, input logic [3:0] x,
                       input logic [3:0] y, input logic uc, input logic [7:0] exp_res,
                       input logic exp_cout, input logic exp_err, input int exp_lat);
    bit got = 0;
    int lat;
    req_op = op; req_x = x; req_y = y; req_use_carry = uc; req_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (req_ready) got = 1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s accept: req_ready never seen within 20 cycles", name);
      return;
    end
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if (lat !== exp_lat) begin
      n_bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_cmp++;
    if (rsp_result !== exp_res) begin
      n_bad++; $display("FAIL %s result: got %h want %h", name, rsp_result, exp_res);
    end
    n_cmp++;
    if (rsp_cout !== exp_cout) begin
      n_bad++; $display("FAIL %s cout: got %b want %b", name, rsp_cout, exp_cout);
    end
    n_cmp++;
    if (rsp_err !== exp_err) begin
      n_bad++; $display("FAIL %s err: got %b want %b", name, rsp_err, exp_err);
    end
    if (rsp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_result, rsp_cout, rsp_err, busy} !== 13'b0) begin
      n_bad++;
      $display("FAIL reset outputs: got rdy=%b vld=%b res=%h cout=%b err=%b busy=%b want all 0",
               req_ready, rsp_valid, rsp_result, rsp_cout, rsp_err, busy);
    end
  endtask

  task automatic test_logic;
    do_op("and",  4'h0, 4'hD, 4'hE, 1'b0, 8'h0C, 1'b0, 1'b0, 2);
    do_op("nand", 4'h1, 4'hD, 4'hE, 1'b0, 8'h03, 1'b0, 1'b0, 2);
  endtask

  task automatic test_arith;
    do_op("add",       4'h8, 4'hD, 4'hE, 1'b0, 8'h0B, 1'b1, 1'b0, 2);
    do_op("add_chain", 4'h8, 4'h9, 4'h5, 1'b1, 8'h0F, 1'b0, 1'b0, 2);
    do_op("sub",       4'h9, 4'h9, 4'h5, 1'b0, 8'h04, 1'b1, 1'b0, 2);
    do_op("sub_borrow",4'h9, 4'hD, 4'hE, 1'b0, 8'h0F, 1'b0, 1'b0, 2);
    do_op("shl",       4'h7, 4'hD, 4'hE, 1'b0, 8'h04, 1'b1, 1'b0, 2);
  endtask

  task automatic test_mult;
    do_op("mult_de", 4'hA, 4'hD, 4'hE, 1'b0, 8'hB6, 1'b0, 1'b0, 5);
    do_op("mult_95", 4'hA, 4'h9, 4'h5, 1'b0, 8'h2D, 1'b0, 1'b0, 5);
    do_op("mult_ff", 4'hA, 4'hF, 4'hF, 1'b0, 8'hE1, 1'b0, 1'b0, 5);
  endtask

  task automatic test_stall_and_illegal;
    rsp_ready = 1'b0;
    do_op("xor_stall", 4'h4, 4'hD, 4'hE, 1'b0, 8'h03, 1'b0, 1'b0, 2);
    req_op = 4'h8; req_x = 4'h1; req_y = 4'h2; req_use_carry = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (!(rsp_valid === 1'b1 && rsp_result === 8'h03 && req_ready === 1'b0)) begin
        n_bad++;
        $display("FAIL stall cycle %0d: got vld=%b res=%h rdy=%b want vld=1 res=03 rdy=0",
                 i, rsp_valid, rsp_result, req_ready);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_ignored_req: got vld=%b busy=%b want 0 0", rsp_valid, busy);
    end
    // carry_flag is 1 from shl; the illegal op must leave it there
    do_op("illegal",   4'hB, 4'h7, 4'h7, 1'b0, 8'h00, 1'b0, 1'b1, 1);
    do_op("flag_kept", 4'h8, 4'h0, 4'h0, 1'b1, 8'h01, 1'b0, 1'b0, 2);
  endtask

  task automatic test_reset_mid_mult;
    bit got = 0;
    do_op("set_flag", 4'h8, 4'hF, 4'h1, 1'b0, 8'h00, 1'b1, 1'b0, 2);
    req_op = 4'hA; req_x = 4'hD; req_y = 4'hE; req_use_carry = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (req_ready) got = 1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL mult_busy: got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("flag_cleared", 4'h8, 4'h1, 4'h1, 1'b1, 8'h02, 1'b0, 1'b0, 2);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_x = '0; req_y = '0;
    req_use_carry = 1'b0; rsp_ready = 1'b1;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_logic();
    test_arith();
    test_mult();
    test_stall_and_illegal();
    test_reset_mid_mult();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
